// File: rtl/dfd_cla_pkg.sv
// Shared types and default widths for the CLA cross-trigger path.
package dfd_cla_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_DROP_W = 8;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RESTART  = 2'd1,
    IGNORE   = 2'd2,
    ONESHOT  = 2'd3
  } xtrig_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } xtrig_shp_state_e;

endpackage

// File: rtl/dfd_xtrigger_pulse_shaper_ch.sv
// One cross-trigger channel: edge detect, stretch/holdoff FSM, drop counter and output mux.
// The FSM state is exported so the parent can derive busy and checkers can bind to it.
module dfd_xtrigger_pulse_shaper_ch
  import dfd_cla_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              xtrigger_in,
  input  xtrig_mode_e       cfg_mode,
  input  logic [CNT_W-1:0]  cfg_stretch,
  input  logic [CNT_W-1:0]  cfg_holdoff,
  input  logic              sw_clear,
  output logic              xtrigger_out,
  output xtrig_shp_state_e  state,
  output logic [DROP_W-1:0] drop_cnt
);

  xtrig_shp_state_e  state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DROP_W-1:0] drop_nx;
  logic              in_d1;
  logic              active;
  logic              posedge_in;
  logic              drop_inc;
  logic              shaped;

  assign posedge_in = xtrigger_in & ~in_d1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      in_d1    <= 1'b0;
      active   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      in_d1    <= xtrigger_in;
      active   <= (state_nx == ACTIVE);
      drop_cnt <= drop_nx;
    end
  end

  // sw_clear outranks a disable, which outranks normal sequencing.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    drop_inc = 1'b0;
    if (sw_clear || (cfg_mode == DISABLED)) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (posedge_in) begin
            state_nx = ACTIVE;
            cnt_nx   = CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (posedge_in && (cfg_mode != IGNORE)) begin
            cnt_nx = CNT_W'(1);
          end else begin
            drop_inc = posedge_in;
            // Zero stretch is sticky: the window never closes on its own.
            if (cfg_stretch != '0) begin
              if (cnt >= cfg_stretch) begin
                if (cfg_holdoff != '0) begin
                  state_nx = HOLDOFF;
                  cnt_nx   = CNT_W'(1);
                end else begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
                end
              end else begin
                cnt_nx = cnt + CNT_W'(1);
              end
            end
          end
        end
        HOLDOFF: begin
          drop_inc = posedge_in;
          if (cnt >= cfg_holdoff) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_comb begin
    drop_nx = drop_cnt;
    if (sw_clear) begin
      drop_nx = '0;
    end else if (drop_inc && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_nx = drop_cnt + DROP_W'(1);
    end
  end

  always_comb begin
    shaped = 1'b0;
    case (cfg_mode)
      DISABLED: shaped = xtrigger_in;
      RESTART:  shaped = xtrigger_in | active;
      IGNORE:   shaped = xtrigger_in | active;
      ONESHOT:  shaped = active;
      default:  shaped = 1'b0;
    endcase
  end

  // Pass-through is combinational, so the output is forced low while reset is held.
  assign xtrigger_out = shaped & reset_n;

endmodule

// File: rtl/dfd_xtrigger_pulse_shaper.sv
// NUM_CH independent cross-trigger pulse shapers between CLA xtrigger sources and the output pins.
module dfd_xtrigger_pulse_shaper
  import dfd_cla_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        xtrigger_in,
  input  logic [NUM_CH*2-1:0]      cfg_mode,
  input  logic [NUM_CH*CNT_W-1:0]  cfg_stretch,
  input  logic [NUM_CH*CNT_W-1:0]  cfg_holdoff,
  input  logic [NUM_CH-1:0]        sw_clear,
  output logic [NUM_CH-1:0]        xtrigger_out,
  output logic [NUM_CH-1:0]        xtrigger_busy,
  output logic [NUM_CH*DROP_W-1:0] drop_cnt
);

  xtrig_shp_state_e ch_state [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dfd_xtrigger_pulse_shaper_ch #(
      .CNT_W  (CNT_W),
      .DROP_W (DROP_W)
    ) u_ch (
      .clock        (clock),
      .reset_n      (reset_n),
      .xtrigger_in  (xtrigger_in[i]),
      .cfg_mode     (xtrig_mode_e'(cfg_mode[2*i +: 2])),
      .cfg_stretch  (cfg_stretch[CNT_W*i +: CNT_W]),
      .cfg_holdoff  (cfg_holdoff[CNT_W*i +: CNT_W]),
      .sw_clear     (sw_clear[i]),
      .xtrigger_out (xtrigger_out[i]),
      .state        (ch_state[i]),
      .drop_cnt     (drop_cnt[DROP_W*i +: DROP_W])
    );

    assign xtrigger_busy[i] = (ch_state[i] != IDLE);
  end

endmodule

// File: tb/tb_dfd_xtrigger_pulse_shaper.sv
// Bench for dfd_xtrigger_pulse_shaper: directed scenarios on channel 0 while the other
// channels run random traffic, then fully random traffic, all against a cycle model.
module tb_dfd_xtrigger_pulse_shaper;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;
  localparam int EW = DROP_W + 2;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  logic [NUM_CH-1:0]        xtrigger_in;
  logic [NUM_CH*2-1:0]      cfg_mode;
  logic [NUM_CH*CNT_W-1:0]  cfg_stretch;
  logic [NUM_CH*CNT_W-1:0]  cfg_holdoff;
  logic [NUM_CH-1:0]        sw_clear;
  logic [NUM_CH-1:0]        xtrigger_out;
  logic [NUM_CH-1:0]        xtrigger_busy;
  logic [NUM_CH*DROP_W-1:0] drop_cnt;

  dfd_xtrigger_pulse_shaper #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DROP_W (DROP_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .xtrigger_in   (xtrigger_in),
    .cfg_mode      (cfg_mode),
    .cfg_stretch   (cfg_stretch),
    .cfg_holdoff   (cfg_holdoff),
    .sw_clear      (sw_clear),
    .xtrigger_out  (xtrigger_out),
    .xtrigger_busy (xtrigger_busy),
    .drop_cnt      (drop_cnt)
  );

  // Per-channel stimulus, packed onto the DUT buses.
  logic             xin    [NUM_CH];
  logic             sw_clr [NUM_CH];
  logic [1:0]       md     [NUM_CH];
  logic [CNT_W-1:0] st     [NUM_CH];
  logic [CNT_W-1:0] ho     [NUM_CH];
  logic [NUM_CH-1:0] rand_mask;

  always_comb begin
    xtrigger_in = '0;
    sw_clear    = '0;
    cfg_mode    = '0;
    cfg_stretch = '0;
    cfg_holdoff = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      xtrigger_in[c]             = xin[c];
      sw_clear[c]                = sw_clr[c];
      cfg_mode[2*c +: 2]         = md[c];
      cfg_stretch[CNT_W*c +: CNT_W] = st[c];
      cfg_holdoff[CNT_W*c +: CNT_W] = ho[c];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_err;
  logic [EW-1:0] exp_q[$];
  logic [NUM_CH-1:0]        s_out;
  logic [NUM_CH-1:0]        s_busy;
  logic [NUM_CH*DROP_W-1:0] s_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 stretching, 2 holdoff; k counts cycles within the current window.
  int   m_phase [NUM_CH];
  int   m_k     [NUM_CH];
  int   m_drop  [NUM_CH];
  logic m_prev  [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_phase[c] = 0;
      m_k[c]     = 0;
      m_drop[c]  = 0;
      m_prev[c]  = 1'b0;
    end
  endtask

  function automatic logic [EW-1:0] model_expect(input int c);
    logic act;
    logic o;
    act = (m_phase[c] == 1);
    case (md[c])
      2'd0:    o = xin[c];
      2'd1:    o = xin[c] | act;
      2'd2:    o = xin[c] | act;
      default: o = act;
    endcase
    return {DROP_W'(m_drop[c]), (m_phase[c] != 0), o};
  endfunction

  task automatic bump_drop(input int c);
    if (m_drop[c] < DROP_MAX) m_drop[c]++;
  endtask

  task automatic model_advance(input int c);
    logic pe;
    pe = xin[c] & ~m_prev[c];
    if (sw_clr[c]) begin
      m_phase[c] = 0; m_k[c] = 0; m_drop[c] = 0;
    end else if (md[c] == 2'd0) begin
      m_phase[c] = 0; m_k[c] = 0;
    end else if (m_phase[c] == 0) begin
      if (pe) begin m_phase[c] = 1; m_k[c] = 1; end
    end else if (m_phase[c] == 1) begin
      if (pe && md[c] != 2'd2) begin
        m_k[c] = 1;
      end else begin
        if (pe) bump_drop(c);
        if (st[c] != 0) begin
          if (m_k[c] >= int'(st[c])) begin
            if (ho[c] != 0) begin m_phase[c] = 2; m_k[c] = 1; end
            else begin m_phase[c] = 0; m_k[c] = 0; end
          end else begin
            m_k[c]++;
          end
        end
      end
    end else begin
      if (pe) bump_drop(c);
      if (m_k[c] >= int'(ho[c])) begin m_phase[c] = 0; m_k[c] = 0; end
      else m_k[c]++;
    end
    m_prev[c] = xin[c];
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_drive(input int c);
    if ($urandom_range(0, 3) == 0) xin[c] = ~xin[c];
    sw_clr[c] = ($urandom_range(0, 59) == 0);
    if ($urandom_range(0, 49) == 0) md[c] = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 29) == 0) st[c] = CNT_W'($urandom_range(0, 6));
    if ($urandom_range(0, 29) == 0) ho[c] = CNT_W'($urandom_range(0, 4));
  endtask

  // One clock cycle: inputs settle, outputs compared at negedge, model advanced.
  task automatic step();
    logic [EW-1:0] w;
    for (int c = 0; c < NUM_CH; c++) if (rand_mask[c]) rand_drive(c);
    @(negedge clock);
    s_out  = xtrigger_out;
    s_busy = xtrigger_busy;
    s_drop = drop_cnt;
    for (int c = 0; c < NUM_CH; c++) exp_q.push_back(model_expect(c));
    for (int c = 0; c < NUM_CH; c++) begin
      w = exp_q.pop_front();
      check($sformatf("out[%0d]", c), 32'(s_out[c]), 32'(w[0]));
      check($sformatf("busy[%0d]", c), 32'(s_busy[c]), 32'(w[1]));
      check($sformatf("drop[%0d]", c), 32'(s_drop[DROP_W*c +: DROP_W]), 32'(w[EW-1:2]));
    end
    for (int c = 0; c < NUM_CH; c++) model_advance(c);
    @(posedge clock);
    #1;
  endtask

  task automatic cfg0(input logic [1:0] m, input int s, input int h);
    md[0] = m;
    st[0] = CNT_W'(s);
    ho[0] = CNT_W'(h);
    xin[0] = 1'b0;
    sw_clr[0] = 1'b1;
    step();
    sw_clr[0] = 1'b0;
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_err    = 0;
    rand_mask = '0;
    reset_n  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      xin[c] = 1'b0; sw_clr[c] = 1'b0; md[c] = 2'd0; st[c] = '0; ho[c] = '0;
    end
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_out", 32'(xtrigger_out), 32'd0);
    check("reset_busy", 32'(xtrigger_busy), 32'd0);
    check("reset_drop", 32'(drop_cnt), 32'd0);
    reset_n = 1'b1;

    for (int c = 1; c < NUM_CH; c++) begin
      md[c] = 2'($urandom_range(0, 3));
      st[c] = CNT_W'($urandom_range(1, 6));
      ho[c] = CNT_W'($urandom_range(0, 3));
    end
    rand_mask = 4'b1110;

    // Single pulse, RESTART, stretch 3.
    cfg0(2'd1, 3, 0);
    for (int t = 0; t <= 8; t++) begin
      xin[0] = (t == 2);
      step();
      check("A_out", 32'(s_out[0]), 32'(t >= 2 && t <= 5));
      check("A_busy", 32'(s_busy[0]), 32'(t >= 3 && t <= 5));
    end
    check("A_drop", 32'(s_drop[DROP_W-1:0]), 32'd0);

    // Retrigger under RESTART extends the window.
    cfg0(2'd1, 3, 0);
    for (int t = 0; t <= 10; t++) begin
      xin[0] = (t == 2 || t == 4);
      step();
      check("B_out", 32'(s_out[0]), 32'(t >= 2 && t <= 7));
      check("B_busy", 32'(s_busy[0]), 32'(t >= 3 && t <= 7));
    end
    check("B_drop", 32'(s_drop[DROP_W-1:0]), 32'd0);

    // Retrigger under IGNORE is dropped.
    cfg0(2'd2, 3, 0);
    for (int t = 0; t <= 10; t++) begin
      xin[0] = (t == 2 || t == 4);
      step();
      check("C_out", 32'(s_out[0]), 32'(t >= 2 && t <= 5));
      check("C_busy", 32'(s_busy[0]), 32'(t >= 3 && t <= 5));
    end
    check("C_drop", 32'(s_drop[DROP_W-1:0]), 32'd1);

    // Holdoff window rejects a pulse, later pulse is accepted.
    cfg0(2'd1, 2, 4);
    for (int t = 0; t <= 18; t++) begin
      xin[0] = (t == 2 || t == 6 || t == 10);
      step();
      check("D_out", 32'(s_out[0]),
            32'(t == 2 || t == 3 || t == 4 || t == 6 || t == 10 || t == 11 || t == 12));
      check("D_busy", 32'(s_busy[0]), 32'((t >= 3 && t <= 8) || (t >= 11 && t <= 16)));
    end
    check("D_drop", 32'(s_drop[DROP_W-1:0]), 32'd1);

    // One-shot with a long level input.
    cfg0(2'd3, 5, 0);
    for (int t = 0; t <= 25; t++) begin
      xin[0] = (t >= 2 && t <= 22);
      step();
      check("E_out", 32'(s_out[0]), 32'(t >= 3 && t <= 7));
    end
    check("E_drop", 32'(s_drop[DROP_W-1:0]), 32'd0);

    // Sticky output, cleared by sw_clear arriving with a posedge.
    cfg0(2'd1, 0, 0);
    for (int t = 0; t <= 42; t++) begin
      xin[0] = (t == 2 || t == 40);
      sw_clr[0] = (t == 40);
      step();
      check("F_out", 32'(s_out[0]), 32'(t >= 2 && t <= 40));
      check("F_busy", 32'(s_busy[0]), 32'(t >= 3 && t <= 40));
    end
    sw_clr[0] = 1'b0;
    check("F_drop", 32'(s_drop[DROP_W-1:0]), 32'd0);

    // Stretch lowered below the running count ends the window next cycle.
    cfg0(2'd1, 200, 0);
    for (int t = 0; t <= 55; t++) begin
      xin[0] = (t == 2);
      st[0] = (t >= 52) ? CNT_W'(5) : CNT_W'(200);
      step();
      if (t >= 50) check("G_busy", 32'(s_busy[0]), 32'(t <= 52));
    end

    // Drop counter saturation.
    cfg0(2'd2, 0, 0);
    for (int t = 0; t < 540; t++) begin
      xin[0] = (t % 2 == 0);
      step();
    end
    check("H_drop_sat", 32'(s_drop[DROP_W-1:0]), 32'(DROP_MAX));
    check("H_busy", 32'(s_busy[0]), 32'd1);

    // Asynchronous reset in the middle of a stretch.
    cfg0(2'd1, 20, 0);
    xin[0] = 1'b1;
    step();
    xin[0] = 1'b0;
    repeat (4) step();
    check("I_pre_busy", 32'(s_busy[0]), 32'd1);
    #2;
    reset_n = 1'b0;
    rand_mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin xin[c] = 1'b0; sw_clr[c] = 1'b0; end
    #1;
    check("I_rst_out", 32'(xtrigger_out), 32'd0);
    check("I_rst_busy", 32'(xtrigger_busy), 32'd0);
    check("I_rst_drop", 32'(drop_cnt), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    step();
    check("I_post_out", 32'(s_out), 32'd0);
    check("I_post_busy", 32'(s_busy), 32'd0);
    check("I_post_drop", 32'(s_drop), 32'd0);

    // Fully random traffic on every channel.
    rand_mask = '1;
    repeat (1500) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
